// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline-control types: hazard FSM states and register address type.
package cpu_pipe_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LOADUSE = 2'd1,
    MISS    = 2'd2
  } state_e;

  typedef logic [4:0] reg_addr_t;

  localparam reg_addr_t REG_X0 = 5'd0;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath (master) and the hazard controller (slave).
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  import cpu_pipe_pkg::*;

  logic             mem_stall_i;
  logic             IDEX_MemRead_i;
  reg_addr_t        IDEX_RDaddr_i;
  reg_addr_t        IFID_RS1addr_i;
  reg_addr_t        IFID_RS2addr_i;
  logic             branch_taken_i;
  logic             PC_write_o;
  logic             IFID_write_o;
  logic             IFID_flush_o;
  logic             pipe_stall_o;
  logic             bubble_o;
  logic [1:0]       state_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] miss_cnt_o;
  logic             timeout_o;

  modport master (
    output mem_stall_i, IDEX_MemRead_i, IDEX_RDaddr_i, IFID_RS1addr_i,
           IFID_RS2addr_i, branch_taken_i,
    input  PC_write_o, IFID_write_o, IFID_flush_o, pipe_stall_o, bubble_o,
           state_o, stall_cnt_o, miss_cnt_o, timeout_o
  );

  modport slave (
    input  mem_stall_i, IDEX_MemRead_i, IDEX_RDaddr_i, IFID_RS1addr_i,
           IFID_RS2addr_i, branch_taken_i,
    output PC_write_o, IFID_write_o, IFID_flush_o, pipe_stall_o, bubble_o,
           state_o, stall_cnt_o, miss_cnt_o, timeout_o
  );

endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous active-low reset and synchronous clear.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      cnt_o <= '0;
    end else if (clr_i) begin
      cnt_o <= '0;
    end else if (inc_i && (cnt_o != '1)) begin
      cnt_o <= cnt_o + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use bubbles, branch flushes and full
// pipeline hold during data-cache misses, plus debug counters and miss timeout.
module hazard_ctrl
  import cpu_pipe_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1024
) (
  input logic          clk_i,
  input logic          rst_i,
  hazard_ctrl_if.slave bus
);

  localparam logic [1:0] S_RUN     = RUN;
  localparam logic [1:0] S_LOADUSE = LOADUSE;
  localparam logic [1:0] S_MISS    = MISS;
  localparam int         WAIT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [1:0]        state_q;
  logic [1:0]        state_d;
  logic              lu;
  logic              pc_write;
  logic              ifid_write;
  logic              ifid_flush;
  logic              pipe_stall;
  logic              bubble;
  logic              miss_entry;
  logic              wait_inc;
  logic              timeout_q;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  miss_cnt;
  logic [WAIT_W-1:0] wait_cnt;

  assign lu = bus.IDEX_MemRead_i && (bus.IDEX_RDaddr_i != REG_X0) &&
              ((bus.IDEX_RDaddr_i == bus.IFID_RS1addr_i) ||
               (bus.IDEX_RDaddr_i == bus.IFID_RS2addr_i));

  // Reset forces a NOP-filling pattern; otherwise miss beats load-use beats branch.
  always_comb begin
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    pipe_stall = 1'b0;
    bubble     = 1'b0;
    miss_entry = 1'b0;
    state_d    = state_q;
    if (!rst_i) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      ifid_flush = 1'b1;
      bubble     = 1'b1;
      state_d    = S_RUN;
    end else if (bus.mem_stall_i) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      pipe_stall = 1'b1;
      miss_entry = (state_q != S_MISS);
      state_d    = S_MISS;
    end else begin
      case (state_q)
        S_LOADUSE: begin
          ifid_flush = bus.branch_taken_i;
          state_d    = S_RUN;
        end
        default: begin
          if (lu) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            bubble     = 1'b1;
            state_d    = S_LOADUSE;
          end else begin
            ifid_flush = bus.branch_taken_i;
            state_d    = S_RUN;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= S_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Wait counter only advances on MISS cycles where the cache is still busy.
  assign wait_inc = rst_i && (state_q == S_MISS) && bus.mem_stall_i;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (pipe_stall | bubble),
    .clr_i (1'b0),
    .cnt_o (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_miss_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (miss_entry),
    .clr_i (1'b0),
    .cnt_o (miss_cnt)
  );

  sat_counter #(.W(WAIT_W)) u_wait_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (wait_inc),
    .clr_i (!wait_inc),
    .cnt_o (wait_cnt)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      timeout_q <= 1'b0;
    end else if ((TIMEOUT != 0) && (wait_cnt == WAIT_W'(TIMEOUT))) begin
      timeout_q <= 1'b1;
    end
  end

  assign bus.PC_write_o   = pc_write;
  assign bus.IFID_write_o = ifid_write;
  assign bus.IFID_flush_o = ifid_flush;
  assign bus.pipe_stall_o = pipe_stall;
  assign bus.bubble_o     = bubble;
  assign bus.state_o      = state_q;
  assign bus.stall_cnt_o  = stall_cnt;
  assign bus.miss_cnt_o   = miss_cnt;
  assign bus.timeout_o    = timeout_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed vector table, hand sequences and random stimulus vs a rule model.
module tb_hazard_ctrl;

  localparam int CNT_W   = 4;
  localparam int TIMEOUT = 8;
  localparam int CMAX    = (1 << CNT_W) - 1;

  typedef struct {
    logic       rst, ms, mr;
    logic [4:0] rd, rs1, rs2;
    logic       br;
    logic       pc, ifw, fl, stl, bub;
    logic [1:0] st;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ms = 1'b0, mr = 1'b0, br = 1'b0;
  logic [4:0] rd = '0, rs1 = '0, rs2 = '0;

  int total = 0;
  int bad   = 0;

  // model state: what happened in the previous (non-reset) cycle
  bit m_prev_stall, m_prev_bubble, m_timeout;
  int m_stall_cnt, m_miss_cnt, m_run_len;
  bit e_pc, e_ifw, e_fl, e_stl, e_bub;

  vec_t tab[21];

  hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

  assign bus.mem_stall_i    = ms;
  assign bus.IDEX_MemRead_i = mr;
  assign bus.IDEX_RDaddr_i  = rd;
  assign bus.IFID_RS1addr_i = rs1;
  assign bus.IFID_RS2addr_i = rs2;
  assign bus.branch_taken_i = br;

  hazard_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic s, input logic m, input int d,
                              input int a1, input int a2, input logic b, input logic pc,
                              input logic ifw, input logic fl, input logic stl,
                              input logic bub, input int st);
    vec_t v;
    v.rst = r; v.ms = s; v.mr = m; v.rd = 5'(d); v.rs1 = 5'(a1); v.rs2 = 5'(a2); v.br = b;
    v.pc = pc; v.ifw = ifw; v.fl = fl; v.stl = stl; v.bub = bub; v.st = 2'(st);
    return v;
  endfunction

  // Expected outputs from the rules, then compare everything visible.
  task automatic half_check();
    bit hz;
    int e_st;
    @(negedge clk);
    hz = mr && (rd != 0) && ((rd == rs1) || (rd == rs2));
    {e_pc, e_ifw, e_fl, e_stl, e_bub} = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    if (!rst) begin
      {e_pc, e_ifw, e_fl, e_stl, e_bub} = {1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    end else if (ms) begin
      {e_pc, e_ifw, e_stl} = {1'b0, 1'b0, 1'b1};
    end else if (hz && !m_prev_bubble) begin
      {e_pc, e_ifw, e_bub} = {1'b0, 1'b0, 1'b1};
    end else begin
      e_fl = br;
    end
    e_st = m_prev_stall ? 2 : (m_prev_bubble ? 1 : 0);
    chk("pc_write",   32'(bus.PC_write_o),   32'(e_pc));
    chk("ifid_write", 32'(bus.IFID_write_o), 32'(e_ifw));
    chk("ifid_flush", 32'(bus.IFID_flush_o), 32'(e_fl));
    chk("pipe_stall", 32'(bus.pipe_stall_o), 32'(e_stl));
    chk("bubble",     32'(bus.bubble_o),     32'(e_bub));
    chk("state",      32'(bus.state_o),      32'(e_st));
    chk("stall_cnt",  32'(bus.stall_cnt_o),  32'(m_stall_cnt));
    chk("miss_cnt",   32'(bus.miss_cnt_o),   32'(m_miss_cnt));
    chk("timeout",    32'(bus.timeout_o),    32'(m_timeout));
  endtask

  task automatic half_adv();
    int cur_len;
    if (!rst) begin
      m_prev_stall = 0; m_prev_bubble = 0; m_timeout = 0;
      m_stall_cnt = 0; m_miss_cnt = 0; m_run_len = 0;
    end else begin
      if ((e_stl || e_bub) && m_stall_cnt < CMAX) m_stall_cnt++;
      if (ms && !m_prev_stall && m_miss_cnt < CMAX) m_miss_cnt++;
      cur_len = ms ? m_run_len + 1 : 0;
      // the first cycle of a stall run is the entry cycle, not a MISS-state cycle
      if (ms && TIMEOUT != 0 && (cur_len - 2) >= TIMEOUT) m_timeout = 1;
      m_run_len     = cur_len;
      m_prev_stall  = ms;
      m_prev_bubble = e_bub;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cycle();
    half_check();
    half_adv();
  endtask

  task automatic idle_inputs();
    ms = 0; mr = 0; br = 0; rd = '0; rs1 = '0; rs2 = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 0;
    cycle();
    rst = 1;
  endtask

  initial begin
    tab[0]  = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 1, 0);
    tab[1]  = mk(1, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0);
    tab[2]  = mk(1, 0, 1, 5, 1, 5, 0,  0, 0, 0, 0, 1, 0);
    tab[3]  = mk(1, 0, 1, 5, 1, 5, 0,  1, 1, 0, 0, 0, 1);
    tab[4]  = mk(1, 0, 1, 0, 0, 3, 0,  1, 1, 0, 0, 0, 0);
    tab[5]  = mk(1, 0, 1, 7, 7, 2, 1,  0, 0, 0, 0, 1, 0);
    tab[6]  = mk(1, 0, 1, 7, 7, 2, 1,  1, 1, 1, 0, 0, 1);
    tab[7]  = mk(1, 1, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0);
    tab[8]  = mk(1, 1, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 2);
    tab[9]  = mk(1, 1, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 2);
    tab[10] = mk(1, 1, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 2);
    tab[11] = mk(1, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 2);
    tab[12] = mk(1, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0);
    tab[13] = mk(1, 1, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0);
    tab[14] = mk(1, 0, 1, 3, 0, 3, 0,  0, 0, 0, 0, 1, 2);
    tab[15] = mk(1, 0, 1, 3, 0, 3, 0,  1, 1, 0, 0, 0, 1);
    tab[16] = mk(1, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0);
    tab[17] = mk(1, 0, 1, 4, 4, 0, 0,  0, 0, 0, 0, 1, 0);
    tab[18] = mk(1, 1, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 1);
    tab[19] = mk(1, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 2);
    tab[20] = mk(1, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0);

    // first edge with reset asserted establishes a known state
    idle_inputs();
    rst = 0;
    @(posedge clk);
    #1;

    // directed vector table
    for (int i = 0; i < 21; i++) begin
      rst = tab[i].rst; ms = tab[i].ms; mr = tab[i].mr; br = tab[i].br;
      rd = tab[i].rd; rs1 = tab[i].rs1; rs2 = tab[i].rs2;
      half_check();
      chk($sformatf("tab%0d_pc", i),    32'(bus.PC_write_o),   32'(tab[i].pc));
      chk($sformatf("tab%0d_ifw", i),   32'(bus.IFID_write_o), 32'(tab[i].ifw));
      chk($sformatf("tab%0d_flush", i), 32'(bus.IFID_flush_o), 32'(tab[i].fl));
      chk($sformatf("tab%0d_stall", i), 32'(bus.pipe_stall_o), 32'(tab[i].stl));
      chk($sformatf("tab%0d_bub", i),   32'(bus.bubble_o),     32'(tab[i].bub));
      chk($sformatf("tab%0d_state", i), 32'(bus.state_o),      32'(tab[i].st));
      half_adv();
    end
    chk("tab_stall_cnt", 32'(bus.stall_cnt_o), 32'd10);
    chk("tab_miss_cnt",  32'(bus.miss_cnt_o),  32'd3);

    // miss timeout: 12 stall cycles, then release
    do_reset();
    ms = 1;
    for (int k = 1; k <= 12; k++) begin
      cycle();
      chk($sformatf("timeout_k%0d", k), 32'(bus.timeout_o), (k >= 10) ? 32'd1 : 32'd0);
    end
    ms = 0;
    cycle();
    cycle();
    chk("timeout_sticky", 32'(bus.timeout_o), 32'd1);

    // reset in the 3rd miss cycle, then re-enter MISS
    do_reset();
    ms = 1;
    cycle();
    cycle();
    rst = 0;
    cycle();
    chk("midmiss_rst_state", 32'(bus.state_o),     32'd0);
    chk("midmiss_rst_scnt",  32'(bus.stall_cnt_o), 32'd0);
    chk("midmiss_rst_mcnt",  32'(bus.miss_cnt_o),  32'd0);
    rst = 1;
    cycle();
    chk("midmiss_reentry_state", 32'(bus.state_o),    32'd2);
    chk("midmiss_reentry_mcnt",  32'(bus.miss_cnt_o), 32'd1);

    // counter saturation
    do_reset();
    ms = 1;
    repeat (20) cycle();
    chk("sat_stall_cnt", 32'(bus.stall_cnt_o), 32'(CMAX));
    for (int k = 0; k < 40; k++) begin
      ms = (k % 2 == 0) ? 1'b0 : 1'b1;
      cycle();
    end
    chk("sat_miss_cnt", 32'(bus.miss_cnt_o), 32'(CMAX));

    // random stimulus against the rule model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 63) != 0);
      ms  = ($urandom_range(0, 3) == 0);
      mr  = ($urandom_range(0, 1) == 1);
      br  = ($urandom_range(0, 9) < 3);
      rd  = 5'($urandom_range(0, 3));
      rs1 = 5'($urandom_range(0, 3));
      rs2 = 5'($urandom_range(0, 3));
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
